seq_rev_shifter: RTL and testbench
==================================

// Module: seq_rev_shifter
// PURPOSE
//  Multi-cycle 16-bit shift unit for the opposite-direction shift ops: SRL, SLA and ROL.
//  Complements the single-cycle SLL/SRA/ROR shifter in the ALU; sits beside it in EX.
//  Uses a valid/ready handshake on input and output; one operation in flight at a time.
//  Shifts up to BITS_PER_CYCLE bits per cycle, trading latency for area.
// PARAMETERS
//  WIDTH           16  operand and result width
//  SHAMT_W         4   shift-amount width (0..2^SHAMT_W-1)
//  BITS_PER_CYCLE  1   maximum bits shifted per SHIFT cycle; legal values 1, 2, 4, 8
// PORTS
//  clk        in   1        single clock; everything is rising-edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        request valid
//  in_ready   out  1        unit can accept a request (high only in IDLE)
//  Shift_In   in   WIDTH    operand
//  Shift_Val  in   SHAMT_W  shift amount
//  Opcode     in   2        [1]=rotate (ROL); else [0]=arith-left (SLA); 00=SRL
//  out_valid  out  1        result valid (DONE state)
//  out_ready  in   1        consumer accepts the result
//  Shift_Out  out  WIDTH    result
//  Z          out  1        1 iff Shift_Out == 0
//  V          out  1        SLA only: any shifted-out bit differed from the original sign; else 0
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, Shift_Out=0, Z=1, V=0, remaining=0.
//  FSM states are IDLE, SHIFT and DONE.
//  IDLE: on in_valid&in_ready, latch the operand, opcode and remaining=Shift_Val, and clear V.
//        If Shift_Val==0, go to DONE; otherwise go to SHIFT.
//  SHIFT: each cycle, k=min(remaining,BITS_PER_CYCLE); shift the data by k; remaining-=k.
//         When remaining becomes 0, go to DONE.
//  Per-op step by k:
//    SRL: zero-fill at the MSB.
//    SLA: zero-fill at the LSB; set V if any of the top k+1 bits differs from bit WIDTH-1.
//         V is sticky for the operation.
//    ROL: bits leaving the MSB re-enter at the LSB.
//  DONE: out_valid=1. Shift_Out, Z and V stay stable until out_valid&out_ready.
//        Then go to IDLE with out_valid=0; Shift_Out, Z and V hold their last values.
//  Latency from accept to out_valid is 1+ceil(Shift_Val/BITS_PER_CYCLE) cycles.
//  Example: amount 0 gives out_valid on the next cycle.
//  in_ready=0 in SHIFT and DONE; a request presented then is ignored and stays pending.
//  No accept in the same cycle as a DONE->IDLE transition; accept one cycle later.
//  Z is computed combinationally from the result register, so Z==(Shift_Out==0) always.
//  rst mid-operation: the operation is discarded and the reset values apply next cycle.
// CONFIGURATION
//  SEQ_REV_SHIFTER_FLUSH_EN:
//    Defined: adds input port flush (1 bit).
//      flush=1 in any state forces IDLE next cycle with out_valid=0 and discards the result.
//      flush has priority over the accept and handshake; rst has priority over flush.
//    Undefined: no flush port; only rst aborts an operation.
// STRUCTURE
//  Package shift_pkg:
//    opcode localparams OP_SRL=2'b00, OP_SLA=2'b01, OP_ROL=2'b10;
//    state encoding ST_IDLE, ST_SHIFT, ST_DONE;
//    WIDTH and SHAMT_W defaults.
//  Sub-module shift_step (combinational), instantiated once:
//    inputs data, k, op; outputs next_data and v_step.
//    Implemented as a log2(BITS_PER_CYCLE)+1 stage mux.
//  Top level holds the FSM, data, remaining, V and output registers.
// TESTING
//  1. SRL 0x8001 by 4, BPC=1 -> 0x0800, Z=0, V=0; out_valid 5 cycles after accept.
//  2. SLA 0x4000 by 1 -> 0x8000, V=1; SLA 0x0003 by 2 -> 0x000C, V=0.
//  3. ROL 0x8001 by 15, BPC=4 -> 0xC000; out_valid 5 cycles after accept.
//  4. SRL 0x00FF by 8 -> 0x0000, Z=1; amount 0 on 0x1234 -> 0x1234, out_valid 1 cycle after accept.
//  5. Hold out_ready=0 for 3 cycles in DONE: outputs stable, in_ready=0, a new in_valid is not accepted.
//  6. Assert rst (and flush, if enabled) in mid-SHIFT: IDLE next cycle, out_valid=0, no result delivered.

Source files
------------

// File: rtl/seq_rev_shifter_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the multi-cycle
// reverse-direction shifter (SRL / SLA / ROL).
package seq_rev_shifter_pkg;
  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLA = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Opcode[1] selects rotate regardless of bit 0; otherwise bit 0 selects SLA.
  function automatic logic is_sla(input logic [1:0] op);
    return !op[1] && op[0];
  endfunction
endpackage

// File: rtl/seq_rev_shifter_if.sv
// Request/response handshake bundle for seq_rev_shifter.
interface seq_rev_shifter_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   Shift_In;
  logic [SHAMT_W-1:0] Shift_Val;
  logic [1:0]         Opcode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   Shift_Out;
  logic               Z;
  logic               V;

  modport master (
    output in_valid, Shift_In, Shift_Val, Opcode, out_ready,
    input  in_ready, out_valid, Shift_Out, Z, V
  );

  modport slave (
    input  in_valid, Shift_In, Shift_Val, Opcode, out_ready,
    output in_ready, out_valid, Shift_Out, Z, V
  );
endinterface

// File: rtl/seq_rev_shifter_shift_step.sv
// One SHIFT-cycle step: shifts data by k (0..BITS_PER_CYCLE) through a
// binary-weighted mux chain and reports SLA overflow for the bits leaving.
module shift_step
  import seq_rev_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] next_data,
  output logic             v_step
);
  logic [KW:0][WIDTH-1:0] stg;

  assign stg[0] = data;

  for (genvar b = 0; b < KW; b++) begin : g_stage
    localparam int S = 1 << b;
    logic [WIDTH-1:0] sh;
    always_comb begin
      if (op[1])      sh = (stg[b] << S) | (stg[b] >> (WIDTH - S));
      else if (op[0]) sh = stg[b] << S;
      else            sh = stg[b] >> S;
    end
    assign stg[b+1] = k[b] ? sh : stg[b];
  end

  assign next_data = stg[KW];

  // Top k+1 bits must all match the sign; bit WIDTH-1 trivially matches itself.
  always_comb begin
    v_step = 1'b0;
    if (is_sla(op)) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= WIDTH - 1 - int'(k) && data[i] != data[WIDTH-1]) v_step = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seq_rev_shifter.sv
// Multi-cycle SRL/SLA/ROL unit, BITS_PER_CYCLE bits per SHIFT cycle.
// Optional SEQ_REV_SHIFTER_FLUSH_EN adds a flush input that aborts to IDLE.
module seq_rev_shifter
  import seq_rev_shifter_pkg::*;
#(
  parameter int WIDTH          = seq_rev_shifter_pkg::WIDTH,
  parameter int SHAMT_W        = seq_rev_shifter_pkg::SHAMT_W,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef SEQ_REV_SHIFTER_FLUSH_EN
  input  logic flush,
`endif
  seq_rev_shifter_if.slave bus
);
  localparam int KW = $clog2(BITS_PER_CYCLE) + 1;

  state_t             state;
  logic [WIDTH-1:0]   data_q, res_q, step_data;
  logic [SHAMT_W-1:0] rem_q, rem_nxt;
  logic [1:0]         op_q;
  logic               v_acc, v_out_q, step_v;
  logic               in_ready_q, out_valid_q;
  logic [KW-1:0]      k;

  always_comb begin
    if (int'(rem_q) > BITS_PER_CYCLE) k = KW'(BITS_PER_CYCLE);
    else                              k = KW'(rem_q);
  end

  assign rem_nxt = rem_q - SHAMT_W'(k);

  shift_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
    .data      (data_q),
    .k         (k),
    .op        (op_q),
    .next_data (step_data),
    .v_step    (step_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      res_q       <= '0;
      rem_q       <= '0;
      op_q        <= OP_SRL;
      v_acc       <= 1'b0;
      v_out_q     <= 1'b0;
    end
`ifdef SEQ_REV_SHIFTER_FLUSH_EN
    else if (flush) begin
      // Result registers keep their last delivered value; only the op is dropped.
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
    end
`endif
    else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.Shift_In;
            op_q       <= bus.Opcode;
            rem_q      <= bus.Shift_Val;
            v_acc      <= 1'b0;
            in_ready_q <= 1'b0;
            if (bus.Shift_Val == '0) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              res_q       <= bus.Shift_In;
              v_out_q     <= 1'b0;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_q <= step_data;
          rem_q  <= rem_nxt;
          v_acc  <= v_acc | step_v;
          if (rem_nxt == '0) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            res_q       <= step_data;
            v_out_q     <= v_acc | step_v;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Shift_Out = res_q;
  assign bus.V         = v_out_q;
  assign bus.Z         = (res_q == '0);
endmodule

// File: tb/tb_seq_rev_shifter.sv
// Directed bench for seq_rev_shifter: one BITS_PER_CYCLE=1 and one =4 instance.
module tb_seq_rev_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef SEQ_REV_SHIFTER_FLUSH_EN
  logic flush = 1'b0;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_rev_shifter_if #(.WIDTH(16), .SHAMT_W(4)) if1 ();
  seq_rev_shifter_if #(.WIDTH(16), .SHAMT_W(4)) if4 ();

  seq_rev_shifter #(.WIDTH(16), .SHAMT_W(4), .BITS_PER_CYCLE(1)) u1 (
    .clk (clk),
    .rst (rst),
`ifdef SEQ_REV_SHIFTER_FLUSH_EN
    .flush (flush),
`endif
    .bus (if1.slave)
  );

  seq_rev_shifter #(.WIDTH(16), .SHAMT_W(4), .BITS_PER_CYCLE(4)) u4 (
    .clk (clk),
    .rst (rst),
`ifdef SEQ_REV_SHIFTER_FLUSH_EN
    .flush (flush),
`endif
    .bus (if4.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit s, input logic v, input logic [1:0] op,
                     input logic [15:0] din, input logic [3:0] amt);
    if (s) begin
      if4.in_valid = v; if4.Opcode = op; if4.Shift_In = din; if4.Shift_Val = amt;
    end else begin
      if1.in_valid = v; if1.Opcode = op; if1.Shift_In = din; if1.Shift_Val = amt;
    end
  endtask

  task automatic set_ordy(input bit s, input logic r);
    if (s) if4.out_ready = r; else if1.out_ready = r;
  endtask

  function automatic logic ov(input bit s);
    return s ? if4.out_valid : if1.out_valid;
  endfunction
  function automatic logic ir(input bit s);
    return s ? if4.in_ready : if1.in_ready;
  endfunction
  function automatic logic [15:0] so(input bit s);
    return s ? if4.Shift_Out : if1.Shift_Out;
  endfunction
  function automatic logic zf(input bit s);
    return s ? if4.Z : if1.Z;
  endfunction
  function automatic logic vf(input bit s);
    return s ? if4.V : if1.V;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accept one request, measure latency to out_valid, check result, then drain.
  task automatic run(input bit s, input string tag, input logic [1:0] op,
                     input logic [15:0] din, input logic [3:0] amt,
                     input logic [15:0] eo, input logic ez, input logic ev, input int elat);
    int lat;
    chk({tag, ".in_ready"}, 32'(ir(s)), 32'd1);
    drv(s, 1'b1, op, din, amt);
    tick();
    drv(s, 1'b0, 2'b00, 16'h0, 4'h0);
    lat = 1;
    while (!ov(s) && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".out"}, 32'(so(s)), 32'(eo));
    chk({tag, ".Z"},   32'(zf(s)), 32'(ez));
    chk({tag, ".V"},   32'(vf(s)), 32'(ev));
    set_ordy(s, 1'b1);
    tick();
    set_ordy(s, 1'b0);
    chk({tag, ".drained"}, 32'(ov(s)), 32'd0);
  endtask

  initial begin
    drv(1'b0, 1'b0, 2'b00, 16'h0, 4'h0);
    drv(1'b1, 1'b0, 2'b00, 16'h0, 4'h0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("rst.in_ready",  32'(if1.in_ready),  32'd1);
    chk("rst.out_valid", 32'(if1.out_valid), 32'd0);
    chk("rst.out",       32'(if1.Shift_Out), 32'h0);
    chk("rst.Z",         32'(if1.Z),         32'd1);
    chk("rst.V",         32'(if1.V),         32'd0);
    chk("rst4.in_ready", 32'(if4.in_ready),  32'd1);

    //  s     tag        op     in       amt    out      Z     V     lat
    run(1'b0, "srl4",    2'b00, 16'h8001, 4'd4,  16'h0800, 1'b0, 1'b0, 5);
    run(1'b0, "sla1",    2'b01, 16'h4000, 4'd1,  16'h8000, 1'b0, 1'b1, 2);
    run(1'b0, "sla2",    2'b01, 16'h0003, 4'd2,  16'h000C, 1'b0, 1'b0, 3);
    run(1'b1, "rol15",   2'b10, 16'h8001, 4'd15, 16'hC000, 1'b0, 1'b0, 5);
    run(1'b0, "srl8",    2'b00, 16'h00FF, 4'd8,  16'h0000, 1'b1, 1'b0, 9);
    run(1'b0, "amt0",    2'b00, 16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0, 1);
    run(1'b1, "sla5b4",  2'b01, 16'h0F00, 4'd5,  16'hE000, 1'b0, 1'b1, 3);
    run(1'b1, "sla3b4",  2'b01, 16'hFFF0, 4'd3,  16'hFF80, 1'b0, 1'b0, 2);
    run(1'b0, "rol4",    2'b10, 16'h1234, 4'd4,  16'h2341, 1'b0, 1'b0, 5);
    run(1'b0, "rol_op11",2'b11, 16'h8000, 4'd1,  16'h0001, 1'b0, 1'b0, 2);
    run(1'b1, "srl15b4", 2'b00, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0, 5);

    // Backpressure in DONE with a competing request pending
    drv(1'b0, 1'b1, 2'b00, 16'hF000, 4'd2);
    tick();
    drv(1'b0, 1'b0, 2'b00, 16'h0, 4'h0);
    repeat (2) tick();
    chk("stall.enter", 32'(if1.out_valid), 32'd1);
    drv(1'b0, 1'b1, 2'b00, 16'hAAAA, 4'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall.valid", 32'(if1.out_valid), 32'd1);
      chk("stall.out",   32'(if1.Shift_Out), 32'h3C00);
      chk("stall.ready", 32'(if1.in_ready),  32'd0);
    end
    set_ordy(1'b0, 1'b1);
    tick();
    set_ordy(1'b0, 1'b0);
    chk("release.valid", 32'(if1.out_valid), 32'd0);
    chk("release.ready", 32'(if1.in_ready),  32'd1);
    chk("release.hold",  32'(if1.Shift_Out), 32'h3C00);
    tick();
    drv(1'b0, 1'b0, 2'b00, 16'h0, 4'h0);
    chk("pending.valid", 32'(if1.out_valid), 32'd1);
    chk("pending.out",   32'(if1.Shift_Out), 32'hAAAA);
    set_ordy(1'b0, 1'b1);
    tick();
    set_ordy(1'b0, 1'b0);

    // V holds after handshake until the next result
    run(1'b0, "sla_v", 2'b01, 16'h4000, 4'd3, 16'h0000, 1'b1, 1'b1, 4);
    chk("vhold.V", 32'(if1.V), 32'd1);

    // Reset mid-SHIFT
    drv(1'b0, 1'b1, 2'b00, 16'hFFFF, 4'd8);
    tick();
    drv(1'b0, 1'b0, 2'b00, 16'h0, 4'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.in_ready",  32'(if1.in_ready),  32'd1);
    chk("midrst.out_valid", 32'(if1.out_valid), 32'd0);
    chk("midrst.out",       32'(if1.Shift_Out), 32'h0);
    chk("midrst.Z",         32'(if1.Z),         32'd1);
    chk("midrst.V",         32'(if1.V),         32'd0);
    repeat (10) tick();
    chk("midrst.no_result", 32'(if1.out_valid), 32'd0);

`ifdef SEQ_REV_SHIFTER_FLUSH_EN
    // Flush mid-SHIFT discards the operation
    drv(1'b0, 1'b1, 2'b10, 16'h00F0, 4'd9);
    tick();
    drv(1'b0, 1'b0, 2'b00, 16'h0, 4'h0);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.in_ready",  32'(if1.in_ready),  32'd1);
    chk("flush.out_valid", 32'(if1.out_valid), 32'd0);
    repeat (10) tick();
    chk("flush.no_result", 32'(if1.out_valid), 32'd0);
    run(1'b0, "post_flush", 2'b00, 16'h0F0F, 4'd4, 16'h00F0, 1'b0, 1'b0, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
